// File: rtl/ans_freq_table_bank.sv
// Multi-bank ANS symbol-frequency table: nibble-serial count load, serial prefix-sum, total check.
// Lookups are registered (1 cycle); a bank is hidden from lookups from load start until a clean finish.
module ans_freq_table_bank #(
   parameter  int SYM_WIDTH   = 4,
   parameter  int CNT_WIDTH   = 4,
   parameter  int NUM_BANKS   = 2,
   parameter  int STRICT_POW2 = 1,
   localparam int SYM_COUNT   = 2**SYM_WIDTH,
   localparam int TOT_W       = SYM_WIDTH + CNT_WIDTH,
   localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_start_i,
   input  logic [BANK_W-1:0]    load_bank_i,
   input  logic                 load_abort_i,
   input  logic [CNT_WIDTH-1:0] in_i,
   input  logic                 in_vld_i,
   output logic                 in_rdy_o,
   output logic                 load_done_o,
   output logic                 load_err_o,
   output logic                 busy_o,
   output logic [NUM_BANKS-1:0] bank_valid_o,
   input  logic                 lk_vld_in_i,
   input  logic [BANK_W-1:0]    lk_bank_i,
   input  logic [SYM_WIDTH-1:0] lk_sym_i,
   output logic                 lk_vld_o,
   output logic [CNT_WIDTH-1:0] lk_freq_o,
   output logic [TOT_W-1:0]     lk_cum_o,
   output logic [TOT_W-1:0]     lk_total_o
);

   typedef enum logic [2:0] {IDLE, LOAD, SUM, CHECK, DONE} state_t;

   localparam logic [BANK_W:0]    NB_W     = NUM_BANKS[BANK_W:0];
   localparam logic [SYM_WIDTH-1:0] LAST_SYM = SYM_WIDTH'(SYM_COUNT - 1);

   state_t                 state_q, state_d;
   logic [BANK_W-1:0]      tgt_q;
   logic [SYM_WIDTH-1:0]   idx_q;
   logic [TOT_W-1:0]       acc_q;
   logic                   err_q;
   logic [NUM_BANKS-1:0]   bank_valid_q;
   logic [CNT_WIDTH-1:0]   cnt_q [NUM_BANKS][SYM_COUNT];
   logic [TOT_W-1:0]       cum_q [NUM_BANKS][SYM_COUNT];
   logic [TOT_W-1:0]       tot_q [NUM_BANKS];

   logic                   lk_vld_q;
   logic [CNT_WIDTH-1:0]   lk_freq_q;
   logic [TOT_W-1:0]       lk_cum_q;
   logic [TOT_W-1:0]       lk_total_q;

   logic                   start_ld, beat, sum_en, chk_en;
   logic [BANK_W-1:0]      ld_bank, lk_bank;
   logic [TOT_W-1:0]       acc_nxt;
   logic                   lk_hit;
   logic                   tot_bad;

   // Out-of-range bank numbers fold back into the populated range.
   function automatic logic [BANK_W-1:0] wrap_bank(input logic [BANK_W-1:0] b);
      return BANK_W'({1'b0, b} % NB_W);
   endfunction

   assign ld_bank = wrap_bank(load_bank_i);
   assign lk_bank = wrap_bank(lk_bank_i);
   assign acc_nxt = acc_q + TOT_W'(cnt_q[tgt_q][idx_q]);
   assign lk_hit  = lk_vld_in_i & bank_valid_q[lk_bank];
   assign tot_bad = (acc_q == '0) ||
                    ((STRICT_POW2 != 0) && ((acc_q & (acc_q - TOT_W'(1))) != '0));

   always_comb begin
      state_d     = state_q;
      in_rdy_o    = 1'b0;
      busy_o      = (state_q != IDLE);
      load_done_o = 1'b0;
      load_err_o  = 1'b0;
      start_ld    = 1'b0;
      beat        = 1'b0;
      sum_en      = 1'b0;
      chk_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_start_i) begin
               start_ld = 1'b1;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            in_rdy_o = 1'b1;
            if (load_abort_i) begin
               state_d = IDLE;
            end else if (in_vld_i) begin
               beat = 1'b1;
               if (idx_q == LAST_SYM) state_d = SUM;
            end
         end
         SUM: begin
            if (load_abort_i) begin
               state_d = IDLE;
            end else begin
               sum_en = 1'b1;
               if (idx_q == LAST_SYM) state_d = CHECK;
            end
         end
         CHECK: begin
            if (load_abort_i) begin
               state_d = IDLE;
            end else begin
               chk_en  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            load_done_o = 1'b1;
            load_err_o  = err_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         tgt_q        <= '0;
         idx_q        <= '0;
         acc_q        <= '0;
         err_q        <= 1'b0;
         bank_valid_q <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            tot_q[b] <= '0;
            for (int s = 0; s < SYM_COUNT; s++) begin
               cnt_q[b][s] <= '0;
               cum_q[b][s] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         if (start_ld) begin
            tgt_q                 <= ld_bank;
            bank_valid_q[ld_bank] <= 1'b0;
            idx_q                 <= '0;
            acc_q                 <= '0;
         end
         if (beat) begin
            cnt_q[tgt_q][idx_q] <= in_i;
            idx_q               <= idx_q + 1'b1;
         end
         // idx wraps to 0 after the last beat, so SUM starts at symbol 0.
         if (sum_en) begin
            cum_q[tgt_q][idx_q] <= acc_q;
            acc_q               <= acc_nxt;
            idx_q               <= idx_q + 1'b1;
            if (idx_q == LAST_SYM) tot_q[tgt_q] <= acc_nxt;
         end
         if (chk_en)      err_q               <= tot_bad;
         if (load_done_o) bank_valid_q[tgt_q] <= ~err_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lk_vld_q   <= 1'b0;
         lk_freq_q  <= '0;
         lk_cum_q   <= '0;
         lk_total_q <= '0;
      end else begin
         lk_vld_q   <= lk_hit;
         lk_freq_q  <= lk_hit ? cnt_q[lk_bank][lk_sym_i] : '0;
         lk_cum_q   <= lk_hit ? cum_q[lk_bank][lk_sym_i] : '0;
         lk_total_q <= lk_hit ? tot_q[lk_bank] : '0;
      end
   end

   assign bank_valid_o = bank_valid_q;
   assign lk_vld_o     = lk_vld_q;
   assign lk_freq_o    = lk_freq_q;
   assign lk_cum_o     = lk_cum_q;
   assign lk_total_o   = lk_total_q;

endmodule

// File: tb/tb_ans_freq_table_bank.sv
// Directed bench for ans_freq_table_bank: lookup results are checked through an expectation queue.
module tb_ans_freq_table_bank;

   typedef struct packed {
      logic       vld;
      logic [3:0] freq;
      logic [7:0] cum;
      logic [7:0] tot;
   } lk_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_start = 1'b0;
   logic [0:0] load_bank = '0;
   logic       load_abort = 1'b0;
   logic [3:0] in = '0;
   logic       in_vld = 1'b0;
   logic       lk_vld_in = 1'b0;
   logic [0:0] lk_bank = '0;
   logic [3:0] lk_sym = '0;

   logic       in_rdy, load_done, load_err, busy, lk_vld;
   logic [1:0] bank_valid;
   logic [3:0] lk_freq;
   logic [7:0] lk_cum, lk_total;

   logic       in_rdy0, load_done0, load_err0, busy0, lk_vld0;
   logic [1:0] bank_valid0;
   logic [3:0] lk_freq0;
   logic [7:0] lk_cum0, lk_total0;

   int  n_vec = 0;
   int  n_err = 0;
   lk_t exp_q[$];
   logic       req_seen;
   logic [3:0] vec [16];
   logic [3:0] tbl [2][16];
   logic       exp_valid [2];

   always #5 clk = ~clk;

   ans_freq_table_bank #(.STRICT_POW2(1)) u_dut (
      .clk_i(clk), .rst_i(rst), .load_start_i(load_start), .load_bank_i(load_bank),
      .load_abort_i(load_abort), .in_i(in), .in_vld_i(in_vld), .in_rdy_o(in_rdy),
      .load_done_o(load_done), .load_err_o(load_err), .busy_o(busy), .bank_valid_o(bank_valid),
      .lk_vld_in_i(lk_vld_in), .lk_bank_i(lk_bank), .lk_sym_i(lk_sym), .lk_vld_o(lk_vld),
      .lk_freq_o(lk_freq), .lk_cum_o(lk_cum), .lk_total_o(lk_total));

   ans_freq_table_bank #(.STRICT_POW2(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .load_start_i(load_start), .load_bank_i(load_bank),
      .load_abort_i(load_abort), .in_i(in), .in_vld_i(in_vld), .in_rdy_o(in_rdy0),
      .load_done_o(load_done0), .load_err_o(load_err0), .busy_o(busy0), .bank_valid_o(bank_valid0),
      .lk_vld_in_i(lk_vld_in), .lk_bank_i(lk_bank), .lk_sym_i(lk_sym), .lk_vld_o(lk_vld0),
      .lk_freq_o(lk_freq0), .lk_cum_o(lk_cum0), .lk_total_o(lk_total0));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic lk_t exp_lk(input int b, input int s);
      lk_t e;
      e = '0;
      if (exp_valid[b]) begin
         e.vld  = 1'b1;
         e.freq = tbl[b][s];
         for (int k = 0; k < 16; k++) begin
            if (k < s) e.cum = e.cum + 8'(tbl[b][k]);
            e.tot = e.tot + 8'(tbl[b][k]);
         end
      end
      return e;
   endfunction

   // Scoreboard: a request sampled at posedge is answered by the next negedge.
   always @(posedge clk or posedge rst) begin
      if (rst) req_seen <= 1'b0;
      else     req_seen <= lk_vld_in;
   end

   always @(negedge clk) begin
      if (!rst && req_seen) begin
         lk_t e;
         check("lk_queue_nonempty", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("lk_vld", lk_vld, e.vld);
            check("lk_freq", lk_freq, e.freq);
            check("lk_cum", lk_cum, e.cum);
            check("lk_total", lk_total, e.tot);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      lk_vld_in  = 1'b0;
      load_start = 1'b0;
      load_abort = 1'b0;
      in_vld     = 1'b0;
   endtask

   task automatic lookup(input int b, input int s);
      lk_vld_in = 1'b1;
      lk_bank   = 1'(b);
      lk_sym    = 4'(s);
      exp_q.push_back(exp_lk(b, s));
   endtask

   task automatic start_load(input int b);
      load_start   = 1'b1;
      load_bank    = 1'(b);
      exp_valid[b] = 1'b0;
      step();
      check("busy_after_start", busy, 1);
      check("in_rdy_in_load", in_rdy, 1);
   endtask

   // Leaves the bench at the negedge of the cycle presenting the last beat.
   task automatic feed(input int nb, input bit rnd, input bit lk);
      int i = 0;
      int cyc = 0;
      while (i < nb && cyc < 500) begin
         in_vld = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
         in     = vec[i];
         check("in_rdy_load", in_rdy, 1);
         if (lk) begin
            lookup(cyc % 2, cyc % 16);
            if (cyc == 3) begin
               load_start = 1'b1;
               load_bank  = 1'b1;
            end
         end
         if (in_vld && in_rdy) i++;
         cyc++;
         if (i < nb) step();
      end
      check("feed_beats", i, nb);
   endtask

   task automatic wait_done(input bit e_err, input bit e_err0, input bit lk);
      int n = 0;
      bit got = 0;
      while (n < 100 && !got) begin
         step();
         n++;
         if (n == 1) begin
            check("in_rdy_sum", in_rdy, 0);
            check("busy_sum", busy, 1);
         end
         if (load_done) got = 1;
         else if (lk) lookup(0, n % 16);
      end
      check("done_latency", n, 18);
      check("load_err", load_err, e_err);
      check("load_done_p0", load_done0, 1);
      check("load_err_p0", load_err0, e_err0);
      if (lk) lookup(0, 0);
   endtask

   task automatic commit(input int b, input bit err);
      if (!err) begin
         exp_valid[b] = 1'b1;
         tbl[b] = vec;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_valid[0] = 1'b0;
      exp_valid[1] = 1'b0;
      for (int b = 0; b < 2; b++) for (int s = 0; s < 16; s++) tbl[b][s] = '0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_in_rdy", in_rdy, 0);
      check("rst_bank_valid", bank_valid, 0);
      check("rst_load_done", load_done, 0);
      check("rst_lk_vld", lk_vld, 0);
      check("rst_lk_total", lk_total, 0);
      rst = 1'b0;
      step();

      // Uniform load into bank 0
      vec = '{default: 4'd1};
      start_load(0);
      feed(16, 0, 0);
      wait_done(0, 0, 0);
      commit(0, 0);
      step();
      check("bank_valid_uni", bank_valid, 2'b01);
      check("in_rdy_idle", in_rdy, 0);
      lookup(0, 5); step();
      lookup(1, 3); step();

      // Skewed load into bank 1 with random in_vld
      vec = '{default: 4'd0};
      vec[0] = 4'd8; vec[1] = 4'd4; vec[2] = 4'd2; vec[3] = 4'd1; vec[4] = 4'd1;
      start_load(1);
      feed(16, 1, 0);
      wait_done(0, 0, 0);
      commit(1, 0);
      step();
      check("bank_valid_skew", bank_valid, 2'b11);
      lookup(1, 3); step();
      lookup(1, 4); step();
      lookup(1, 15); step();
      lookup(1, 0); step();

      // All-zero counts rejected by both variants
      vec = '{default: 4'd0};
      start_load(0);
      feed(16, 0, 0);
      wait_done(1, 1, 0);
      step();
      check("bank_valid_zero", bank_valid, 2'b10);
      lookup(0, 5); step();

      // Total 17: rejected only when a power of two is required
      vec = '{default: 4'd1};
      vec[0] = 4'd2;
      start_load(0);
      feed(16, 0, 0);
      wait_done(1, 0, 0);
      step();
      check("bank_valid_17", bank_valid, 2'b10);

      // Abort after 7 beats; the simultaneous 8th beat is dropped
      vec = '{default: 4'd1};
      start_load(0);
      feed(7, 0, 0);
      step();
      load_abort = 1'b1;
      in_vld     = 1'b1;
      in         = 4'd1;
      step();
      check("busy_after_abort", busy, 0);
      check("in_rdy_after_abort", in_rdy, 0);
      for (int k = 0; k < 20; k++) begin
         check("no_done_after_abort", load_done, 0);
         step();
      end
      check("bank_valid_abort", bank_valid, 2'b10);

      start_load(0);
      feed(16, 0, 0);
      wait_done(0, 0, 0);
      commit(0, 0);
      step();
      check("bank_valid_reload", bank_valid, 2'b11);
      lookup(0, 15); step();

      // Reload bank 0 while bank 1 is looked up every other cycle; extra load_start ignored
      vec = '{default: 4'd0};
      vec[7] = 4'd15; vec[9] = 4'd1;
      start_load(0);
      feed(16, 0, 1);
      wait_done(0, 0, 1);
      commit(0, 0);
      step();
      check("bank_valid_conc", bank_valid, 2'b11);
      lookup(0, 7); step();
      lookup(0, 8); step();
      lookup(0, 10); step();
      lookup(1, 2); step();

      // Reset during SUM with a lookup result on the outputs
      vec = '{default: 4'd1};
      start_load(1);
      feed(16, 0, 0);
      step();
      step();
      lookup(0, 9);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_in_rdy", in_rdy, 0);
      check("midrst_bank_valid", bank_valid, 0);
      check("midrst_load_done", load_done, 0);
      check("midrst_lk_vld", lk_vld, 0);
      check("midrst_lk_total", lk_total, 0);
      exp_q.delete();
      exp_valid[0] = 1'b0;
      exp_valid[1] = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("postrst_bank_valid", bank_valid, 0);
      check("postrst_busy", busy, 0);
      lookup(1, 3); step();
      step();
      check("lk_queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
